// File: rtl/clock_set_controller.sv
// Two-button time-setting controller: debounces MODE/INC, walks RUN -> SET_HR -> SET_MIN -> COMMIT,
// blinks the field under edit and drops an abandoned edit after an inactivity timeout.
//
// state   | meaning
// RUN     | timekeeper counting, buttons only watched for MODE
// SET_HR  | counters frozen, INC steps the edit hour
// SET_MIN | counters frozen, INC steps the edit minute
// COMMIT  | one-cycle load of the edited time, then back to RUN
module clock_set_controller #(
    parameter int DEB_CYCLES    = 500000,
    parameter int TICK_DIV      = 50000000,
    parameter int BLINK_DIV     = 12500000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       run_en,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic       blank_hr,
    output logic       blank_min,
    output logic [1:0] mode_state
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDLE_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TICK_W-1:0]  TICK_MAX   = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(TIMEOUT_TICKS);

    logic [1:0]            btnRaw;
    logic [1:0]            sync1, sync2, debLevel, debPrev, armed, pulse;
    logic [1:0]            pipeFill;
    logic [1:0][DEB_W-1:0] debCnt;
    logic                  modeP, incP;

    assign btnRaw = {btn_inc, btn_mode};

    // A button held through reset must be seen released before it may generate a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            debLevel <= '0;
            debPrev  <= '0;
            armed    <= '0;
            pipeFill <= '0;
            debCnt   <= '0;
        end else begin
            sync1    <= btnRaw;
            sync2    <= sync1;
            debPrev  <= debLevel;
            pipeFill <= {pipeFill[0], 1'b1};
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] == debLevel[b]) begin
                    debCnt[b] <= DEB_MAX;
                end else if (debCnt[b] == '0) begin
                    debLevel[b] <= sync2[b];
                    debCnt[b]   <= DEB_MAX;
                end else begin
                    debCnt[b] <= debCnt[b] - DEB_W'(1);
                end
                if (pipeFill[1] && !sync2[b]) armed[b] <= 1'b1;
            end
        end
    end

    assign pulse = debLevel & ~debPrev & armed;
    assign modeP = pulse[0];
    assign incP  = pulse[1];

    logic [TICK_W-1:0]  tickCnt;
    logic [BLINK_W-1:0] blinkCnt;
    logic               tick, blinkWrap, blinkPhase, blinkNext;

    assign tick      = (tickCnt == '0);
    assign blinkWrap = (blinkCnt == '0);
    assign blinkNext = blinkPhase ^ blinkWrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            tickCnt    <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
        end else begin
            tickCnt    <= tick ? TICK_MAX : tickCnt - TICK_W'(1);
            blinkCnt   <= blinkWrap ? BLINK_MAX : blinkCnt - BLINK_W'(1);
            blinkPhase <= blinkNext;
        end
    end

    logic [1:0]        state, stateNext;
    logic [4:0]        editHour, editHourNext;
    logic [5:0]        editMin, editMinNext;
    logic [IDLE_W-1:0] idleCnt, idleNext;
    logic              editing;

    assign editing = (state == ST_SET_HR) || (state == ST_SET_MIN);

    // MODE outranks INC, and any press outranks the inactivity timeout.
    always_comb begin
        stateNext    = state;
        editHourNext = editHour;
        editMinNext  = editMin;
        idleNext     = idleCnt;
        if (tick && editing && (idleCnt != IDLE_LIMIT)) idleNext = idleCnt + IDLE_W'(1);
        case (state)
            ST_RUN: begin
                if (modeP) begin
                    stateNext    = ST_SET_HR;
                    editHourNext = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
                    editMinNext  = (cur_min > 6'd59) ? 6'd0 : cur_min;
                end
            end
            ST_SET_HR: begin
                if (modeP)                     stateNext    = ST_SET_MIN;
                else if (incP)                 editHourNext = (editHour == 5'd23) ? 5'd0 : editHour + 5'd1;
                else if (idleCnt == IDLE_LIMIT) stateNext   = ST_RUN;
            end
            ST_SET_MIN: begin
                if (modeP)                     stateNext   = ST_COMMIT;
                else if (incP)                 editMinNext = (editMin == 6'd59) ? 6'd0 : editMin + 6'd1;
                else if (idleCnt == IDLE_LIMIT) stateNext  = ST_RUN;
            end
            default: stateNext = ST_RUN;
        endcase
        if (modeP || incP) idleNext = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            editHour  <= '0;
            editMin   <= '0;
            idleCnt   <= '0;
            run_en    <= 1'b1;
            load      <= 1'b0;
            blank_hr  <= 1'b0;
            blank_min <= 1'b0;
        end else begin
            state     <= stateNext;
            editHour  <= editHourNext;
            editMin   <= editMinNext;
            idleCnt   <= idleNext;
            run_en    <= (stateNext == ST_RUN);
            load      <= (stateNext == ST_COMMIT);
            blank_hr  <= (stateNext == ST_SET_HR) && blinkNext;
            blank_min <= (stateNext == ST_SET_MIN) && blinkNext;
        end
    end

    assign mode_state = state;
    assign load_hour  = editHour;
    assign load_min   = editMin;

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Time-setting controller for the digital clock timekeeper: a two-button (MODE/INC) state machine that pauses timekeeping, lets the user edit hours then minutes, and commits the new time with a one-cycle load strobe. It sits between the board push-buttons and the hour/minute/second counters. It also drives digit-blanking for the field being edited, and abandons an edit after a period of inactivity.

## Interface
Parameters:
- DEB_CYCLES, 500000: consecutive stable samples required to accept a button level change.
- TICK_DIV, 50000000: clk cycles per one-second inactivity tick.
- BLINK_DIV, 12500000: clk cycles per blink-phase toggle.
- TIMEOUT_TICKS, 10: one-second ticks without a press before an edit is abandoned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw MODE button, asynchronous, active-high.
- btn_inc  in  1  raw INC button, asynchronous, active-high.
- cur_hour  in  5  live hour from timekeeper (0-23).
- cur_min  in  6  live minute from timekeeper (0-59).
- run_en  out  1  timekeeper count enable; 0 freezes counters.
- load  out  1  one-cycle strobe: timekeeper takes load_hour/load_min, sets seconds to 0.
- load_hour  out  5  hour to load; equals edit hour.
- load_min  out  6  minute to load; equals edit minute.
- blank_hr  out  1  blank both hour digits this cycle.
- blank_min  out  1  blank both minute digits this cycle.
- mode_state  out  2  current state encoding, for display and debug.

## Operation
- Button path, per button:
  - 2-FF synchronizer, then debounce counter.
  - The debounced level changes only after DEB_CYCLES consecutive samples differ from it.
  - A rising edge of the debounced level produces a one-cycle press pulse (mode_p / inc_p).
  - Releases produce no pulse. No auto-repeat.
- States (mode_state encoding): RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3.
- RUN:
  - run_en=1.
  - On mode_p: edit_hour <= cur_hour, or 0 if cur_hour>23. edit_min <= cur_min, or 0 if cur_min>59. Go to SET_HR.
  - inc_p is ignored.
- SET_HR:
  - run_en=0.
  - On inc_p: edit_hour <= (edit_hour==23) ? 0 : edit_hour+1.
  - On mode_p: go to SET_MIN.
- SET_MIN:
  - run_en=0.
  - On inc_p: edit_min <= (edit_min==59) ? 0 : edit_min+1.
  - On mode_p: go to COMMIT.
- COMMIT:
  - run_en=0, load=1 for exactly this one cycle.
  - Unconditionally go to RUN next cycle.
  - Presses arriving in COMMIT are dropped.
- Simultaneous mode_p and inc_p in the same cycle: mode_p wins and inc_p is discarded.
- Inactivity timeout:
  - The tick counter free-runs 0..TICK_DIV-1.
  - idle_cnt clears on entry to SET_HR and on every mode_p/inc_p. It increments on each tick wrap while in SET_HR or SET_MIN.
  - When idle_cnt reaches TIMEOUT_TICKS, go to RUN with no load; edits are discarded.
  - A press in the same cycle as the timeout takes priority over the timeout.
- Blink:
  - blink_phase toggles every BLINK_DIV cycles; the counter is free-running.
  - blank_hr = (state==SET_HR) & blink_phase.
  - blank_min = (state==SET_MIN) & blink_phase.
  - Both are 0 in RUN and COMMIT.
- load_hour and load_min always mirror edit_hour and edit_min; they are meaningful only while load=1.
- Arithmetic: edit registers are 5-bit (hour) and 6-bit (minute). The compare-then-wrap above is used; no modulo hardware.

## Timing
- Reset values:
  - Outputs: state=RUN, run_en=1, load=0, load_hour=0, load_min=0, blank_hr=0, blank_min=0, mode_state=0.
  - Internals: all counters 0, debounced levels 0, blink_phase 0, sync FFs 0.
- Press latency: a raw edge stable from cycle 0 gives its press pulse at cycle 2+DEB_CYCLES, ±1 cycle.
- State/edit registers update on the clk edge at the end of the pulse cycle. mode_state, run_en, and blanks are registered and change 1 cycle after the pulse.
- load is high in the cycle immediately after the SET_MIN mode_p cycle. run_en returns to 1 the cycle after load.
- rst asserted mid-edit: next cycle returns to RUN with run_en=1 and load=0; edits are lost and no load is issued.
- rst held during a press: no pulse is generated after release of rst unless a new rising edge occurs.

## Test plan
Bench parameters: DEB_CYCLES=4, TICK_DIV=10, BLINK_DIV=5, TIMEOUT_TICKS=3.

1. Reset then idle 50 cycles -> run_en=1, load=0, mode_state=0, both blanks 0 throughout.
2. cur_hour=22, cur_min=58. Press MODE, INC×3, MODE, INC×2, MODE -> one load pulse with load_hour=1, load_min=0. mode_state sequence 0,1,2,3,0. run_en=0 from SET_HR through COMMIT.
3. Bounce: btn_inc toggled every 2 cycles for 20 cycles, then held high -> exactly one inc_p; edit_hour +1.
4. Enter SET_HR and wait 30+ cycles with no press -> returns to RUN after 3 ticks; load never asserted.
5. In SET_MIN, drive mode_p and inc_p in the same cycle -> COMMIT entered; edit_min unchanged.
6. cur_hour=27 at MODE press -> edit_hour=0. Assert rst in SET_MIN -> RUN next cycle, load stays 0; blank_hr/blank_min toggled with period 10 cycles only while in their respective set states.
